l2_cache_control: RTL and testbench
===================================

# l2_cache_control

Control block for the direct-mapped, write-back L2 cache. Accepts line-granular read and byte-masked write requests from the L1 side. Drives the L2 data array through its read, byte write-enable, index and data ports, and keeps tag, valid and dirty state internally. On a miss it issues dirty-victim writebacks and line fills on the memory-side line interface.

## Interface
Parameters:
- s_offset, 5, log2 bytes per line
- s_index, 3, log2 number of sets
- s_tag, 32-s_offset-s_index, tag width
- s_mask, 2**s_offset, bytes per line
- s_line, 8*s_mask, bits per line

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- up_address  in  32  request address; bits [s_offset-1:0] ignored
- up_read  in  1  line read request; held until up_resp
- up_write  in  1  masked write request; held until up_resp
- up_byte_enable  in  s_mask  per-byte write mask
- up_wdata  in  s_line  write line
- up_rdata  out  s_line  read line; valid while up_resp=1
- up_resp  out  1  one-cycle completion pulse
- mem_address  out  32  line-aligned memory address
- mem_read  out  1  fill request; held until mem_resp
- mem_write  out  1  writeback request; held until mem_resp
- mem_wdata  out  s_line  victim line
- mem_rdata  in  s_line  fill line; valid with mem_resp
- mem_resp  in  1  memory completion pulse
- arr_read  out  1  data-array read strobe
- arr_write_en  out  s_mask  data-array byte write enables
- arr_index  out  s_index  data-array set index
- arr_datain  out  s_line  data-array write line
- arr_dataout  in  s_line  data-array read line; valid the cycle after arr_read

## Operation
- State set: IDLE, TAG, WB, FILL, REREAD.
- Index is up_address[s_offset+:s_index]. Tag is up_address[31-:s_tag].
- **IDLE**: on up_read or up_write, assert arr_read with arr_index and go to TAG. If both requests are high, the request is handled as a write.
- **TAG**: compare the tag and valid bit for the indexed set.
  - Read hit: up_rdata=arr_dataout, up_resp=1, go to IDLE.
  - Write hit: arr_write_en=up_byte_enable, arr_datain=up_wdata, set dirty, up_resp=1, go to IDLE.
  - Miss with dirty victim: register arr_dataout as the victim line and go to WB.
  - Miss with clean or invalid set: go to FILL.
- **WB**: mem_write=1, mem_address={victim tag, index, 0}, mem_wdata=victim register. On mem_resp, go to FILL.
- **FILL**: mem_read=1, mem_address={tag, index, 0}. On mem_resp: arr_write_en all ones, arr_datain=mem_rdata, write the tag, valid=1, dirty=0, go to REREAD.
- **REREAD**: arr_read=1, go to TAG. TAG now hits, so a write miss merges its bytes over the filled line and sets dirty.
- arr_write_en is zero in every other state/cycle. arr_read is high only in the IDLE accept cycle and in REREAD.
- mem_read and mem_write are never high together.
- Reset:
  - All valid and dirty bits clear; state goes to IDLE.
  - up_resp, mem_read, mem_write, arr_read and arr_write_en are 0.
  - Data-array contents are not cleared.
  - Reset during WB or FILL abandons the transaction; requests drop the cycle after rst is sampled.

## Timing
- Hit: request sampled in IDLE at edge N; up_resp high in cycle N+1.
- Clean miss: 1 (IDLE) + 1 (TAG) + memory latency + 1 (REREAD) + 1 (TAG) cycles.
- Dirty miss adds the WB memory latency.
- No back-to-back acceptance: after up_resp the block spends at least one cycle in IDLE before the next request.
- Array write and array read are never issued for the same index in the same cycle.

## Structure
- Package l2_cache_pkg:
  - state enum (IDLE, TAG, WB, FILL, REREAD)
  - parameter defaults
  - address field-extraction functions (tag, index)
- Sub-module l2_tag_array: tag/valid/dirty storage per set, with combinational read, synchronous write, and synchronous clear on rst.

## Test plan
- **Reset, then read** of 0x0000_0040: first cycle in TAG misses, so mem_read=1 with mem_address=0x0000_0040. After mem_resp with a line of 0xA5 bytes, arr_write_en=all ones, then REREAD, then TAG, then up_resp with up_rdata of all 0xA5.
- **Repeat read** of 0x0000_0040: up_resp exactly 1 cycle after acceptance; mem_read stays 0.
- **Write hit** to 0x0000_0040 with byte_enable=0x0000_0001 and data byte 0x3C: arr_write_en=0x1 in the TAG cycle. A subsequent read returns byte0=0x3C and all other bytes 0xA5.
- **Dirty conflict** on read of 0x0000_0140 (same index, different tag): mem_write=1 with mem_address=0x0000_0040 and mem_wdata byte0=0x3C. After mem_resp, mem_read=1 with mem_address=0x0000_0140.
- **Reset mid-FILL**: assert rst while mem_read=1. mem_read=0 the next cycle; a later read of the same line misses again.

Source files
------------

// File: rtl/l2_cache_pkg.sv
// rtl/l2_cache_pkg.sv - shared state encoding, default geometry and address helpers for the L2 controller
package l2_cache_pkg;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int S_MASK   = 2 ** S_OFFSET;
  localparam int S_LINE   = 8 * S_MASK;

  typedef enum logic [2:0] {
    IDLE,
    TAG,
    WB,
    FILL,
    REREAD
  } state_t;

  // Both helpers return a right-justified field; callers slice to their own width.
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int off, input int idx);
    return (addr >> off) & ((32'd1 << idx) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off, input int idx);
    return addr >> (off + idx);
  endfunction

endpackage

// File: rtl/l2_tag_array.sv
// rtl/l2_tag_array.sv - per-set tag/valid/dirty storage with combinational lookup
module l2_tag_array #(
  parameter int s_index = 3,
  parameter int s_tag   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_index-1:0] index,
  output logic [s_tag-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic               fill,
  input  logic [s_tag-1:0]   fill_tag,
  input  logic               set_dirty
);

  localparam int sets = 2 ** s_index;

  logic [s_tag-1:0] tags [sets];
  logic [sets-1:0]  valid;
  logic [sets-1:0]  dirty;

  assign rd_tag   = tags[index];
  assign rd_valid = valid[index];
  assign rd_dirty = dirty[index];

  // Tags need no reset: they are only trusted when the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill) tags[index] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (set_dirty) begin
      dirty[index] <= 1'b1;
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// rtl/l2_cache_control.sv - direct-mapped write-back L2 controller: lookup, victim writeback, line fill
module l2_cache_control
  import l2_cache_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_index  = S_INDEX,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_mask   = 2 ** s_offset,
  parameter int s_line   = 8 * s_mask
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        up_address,
  input  logic               up_read,
  input  logic               up_write,
  input  logic [s_mask-1:0]  up_byte_enable,
  input  logic [s_line-1:0]  up_wdata,
  output logic [s_line-1:0]  up_rdata,
  output logic               up_resp,
  output logic [31:0]        mem_address,
  output logic               mem_read,
  output logic               mem_write,
  output logic [s_line-1:0]  mem_wdata,
  input  logic [s_line-1:0]  mem_rdata,
  input  logic               mem_resp,
  output logic               arr_read,
  output logic [s_mask-1:0]  arr_write_en,
  output logic [s_index-1:0] arr_index,
  output logic [s_line-1:0]  arr_datain,
  input  logic [s_line-1:0]  arr_dataout
);

  state_t              state;
  logic [s_line-1:0]   victim;
  logic [31:0]         index_full;
  logic [31:0]         tag_full;
  logic [s_index-1:0]  index;
  logic [s_tag-1:0]    tag;
  logic [s_tag-1:0]    rd_tag;
  logic                rd_valid;
  logic                rd_dirty;
  logic                hit;
  logic                fill;
  logic                set_dirty;
  logic                unused_bits;

  assign index_full  = addr_index(up_address, s_offset, s_index);
  assign tag_full    = addr_tag(up_address, s_offset, s_index);
  assign index       = index_full[s_index-1:0];
  assign tag         = tag_full[s_tag-1:0];
  assign unused_bits = ^{index_full[31:s_index], up_address[s_offset-1:0]};
  assign hit         = rd_valid && (rd_tag == tag);

  l2_tag_array #(
    .s_index(s_index),
    .s_tag  (s_tag)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .index    (index),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .fill     (fill),
    .fill_tag (tag),
    .set_dirty(set_dirty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:   if (up_read || up_write) state <= TAG;
        TAG: begin
          if (hit) begin
            state <= IDLE;
          end else if (rd_valid && rd_dirty) begin
            victim <= arr_dataout;
            state  <= WB;
          end else begin
            state <= FILL;
          end
        end
        WB:     if (mem_resp) state <= FILL;
        FILL:   if (mem_resp) state <= REREAD;
        REREAD: state <= TAG;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are forced low while rst is high so nothing leaks out during reset.
  always_comb begin
    up_resp      = 1'b0;
    up_rdata     = arr_dataout;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = {tag, index, {s_offset{1'b0}}};
    mem_wdata    = victim;
    arr_read     = 1'b0;
    arr_write_en = '0;
    arr_index    = index;
    arr_datain   = up_wdata;
    fill         = 1'b0;
    set_dirty    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:   arr_read = up_read || up_write;
        TAG: begin
          if (hit) begin
            up_resp = 1'b1;
            if (up_write) begin
              arr_write_en = up_byte_enable;
              set_dirty    = 1'b1;
            end
          end
        end
        WB: begin
          mem_write   = 1'b1;
          mem_address = {rd_tag, index, {s_offset{1'b0}}};
        end
        FILL: begin
          mem_read = 1'b1;
          if (mem_resp) begin
            arr_write_en = '1;
            arr_datain   = mem_rdata;
            fill         = 1'b1;
          end
        end
        REREAD: arr_read = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_control.sv
// tb/tb_l2_cache_control.sv - directed bench with a transaction-level cache/memory model
module tb_l2_cache_control;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  up_address;
  logic         up_read;
  logic         up_write;
  logic [31:0]  up_byte_enable;
  logic [255:0] up_wdata;
  logic [255:0] up_rdata;
  logic         up_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         arr_read;
  logic [31:0]  arr_write_en;
  logic [2:0]   arr_index;
  logic [255:0] arr_datain;
  logic [255:0] arr_dataout;

  always #5 clk = ~clk;

  l2_cache_control dut (
    .clk           (clk),
    .rst           (rst),
    .up_address    (up_address),
    .up_read       (up_read),
    .up_write      (up_write),
    .up_byte_enable(up_byte_enable),
    .up_wdata      (up_wdata),
    .up_rdata      (up_rdata),
    .up_resp       (up_resp),
    .mem_address   (mem_address),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_resp      (mem_resp),
    .arr_read      (arr_read),
    .arr_write_en  (arr_write_en),
    .arr_index     (arr_index),
    .arr_datain    (arr_datain),
    .arr_dataout   (arr_dataout)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Data array: one-cycle read latency, byte-masked write.
  logic [255:0] darr [8] = '{default: '0};
  always @(posedge clk) begin
    for (int b = 0; b < 32; b++)
      if (arr_write_en[b]) darr[arr_index][b*8 +: 8] <= arr_datain[b*8 +: 8];
    if (arr_read) arr_dataout <= darr[arr_index];
  end

  // Backing memory, shared by the responder and the model.
  logic [255:0] ref_mem [logic [31:0]];
  int mem_lat = 3;
  int mcnt = 0;

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return {32{a[15:8] ^ a[7:0] ^ 8'h5A}};
  endfunction

  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp = 1'b0;
      if (mem_read || mem_write) begin
        mcnt++;
        if (mcnt >= mem_lat) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_line(mem_address);
          mcnt      = 0;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  // Cache model: what each set holds, independent of how the controller sequences it.
  bit           mvalid [8];
  bit           mdirty [8];
  logic [23:0]  mtag   [8];
  logic [255:0] mline  [8];

  bit           exp_active = 0;
  bit           exp_write, exp_miss, exp_wb;
  logic [31:0]  exp_be, exp_wb_addr, exp_fill_addr;
  logic [255:0] exp_rdata, exp_wb_data;
  int           exp_lat;

  bit           saw_read, saw_write;
  logic [31:0]  obs_fill_addr, obs_wb_addr;
  logic [255:0] obs_wb_data;

  task automatic predict(input bit wr, input logic [31:0] addr, input logic [31:0] be, input logic [255:0] wd);
    int idx;
    logic [23:0] tg;
    bit hit;
    idx = int'(addr[7:5]);
    tg  = addr[31:8];
    hit = mvalid[idx] && (mtag[idx] == tg);
    exp_write     = wr;
    exp_be        = be;
    exp_miss      = !hit;
    exp_wb        = !hit && mvalid[idx] && mdirty[idx];
    exp_wb_addr   = {mtag[idx], addr[7:5], 5'b0};
    exp_wb_data   = mline[idx];
    exp_fill_addr = {addr[31:5], 5'b0};
    if (exp_wb) ref_mem[exp_wb_addr] = mline[idx];
    if (!hit) begin
      mline[idx]  = mem_line(exp_fill_addr);
      mtag[idx]   = tg;
      mvalid[idx] = 1'b1;
      mdirty[idx] = 1'b0;
    end
    exp_rdata = mline[idx];
    if (wr) begin
      for (int b = 0; b < 32; b++)
        if (be[b]) mline[idx][b*8 +: 8] = wd[b*8 +: 8];
      mdirty[idx] = 1'b1;
    end
    exp_lat = hit ? 1 : (exp_wb ? 3 + 2 * mem_lat : 3 + mem_lat);
  endtask

  // Cycle-by-cycle compare against the model's expectations.
  initial begin
    logic [31:0] ew;
    forever begin
      @(negedge clk);
      if (!rst && exp_active) begin
        if (mem_read && mem_write) check("mem_rw_exclusive", 1'b1, 1'b0);
        if (mem_write) begin
          if (!exp_wb) check("unexpected_wb", mem_write, 1'b0);
          check("wb_addr", mem_address, exp_wb_addr);
          check("wb_data", mem_wdata, exp_wb_data);
          if (!saw_write) begin
            obs_wb_addr = mem_address;
            obs_wb_data = mem_wdata;
            saw_write   = 1'b1;
          end
        end
        if (mem_read) begin
          if (!exp_miss) check("unexpected_fill", mem_read, 1'b0);
          check("fill_addr", mem_address, exp_fill_addr);
          if (!saw_read) begin
            obs_fill_addr = mem_address;
            saw_read      = 1'b1;
          end
        end
        if (up_resp && !exp_write) check("rdata", up_rdata, exp_rdata);
        ew = (up_resp && exp_write) ? exp_be : ((mem_read && mem_resp) ? 32'hFFFF_FFFF : 32'h0);
        check("arr_write_en", arr_write_en, ew);
      end else if (!rst) begin
        check("idle_quiet", {up_resp, mem_read, mem_write, |arr_write_en}, 4'b0);
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] be,
                        input logic [255:0] wd, output logic [255:0] rdata, output int lat);
    int acc;
    bit got;
    @(posedge clk); #1;
    predict(wr, addr, be, wd);
    saw_read       = 1'b0;
    saw_write      = 1'b0;
    up_address     = addr;
    up_byte_enable = be;
    up_wdata       = wd;
    up_read        = rd;
    up_write       = wr;
    exp_active     = 1'b1;
    acc   = cyc;
    got   = 1'b0;
    rdata = '0;
    lat   = -1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(posedge clk); #1;
      if (up_resp) begin
        got   = 1'b1;
        rdata = up_rdata;
        lat   = cyc - acc;
      end
    end
    if (!got) check("resp_timeout", 1'b0, 1'b1);
    else check("latency", lat, exp_lat);
    @(posedge clk); #1;
    up_read    = 1'b0;
    up_write   = 1'b0;
    exp_active = 1'b0;
  endtask

  initial begin
    logic [255:0] rd;
    int lat;
    rst = 1'b1;
    up_address = '0; up_read = 1'b0; up_write = 1'b0; up_byte_enable = '0; up_wdata = '0;
    ref_mem[32'h40] = {32{8'hA5}};
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {up_resp, mem_read, mem_write, arr_read, |arr_write_en}, 5'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", {up_resp, mem_read, mem_write, arr_read, |arr_write_en}, 5'b0);

    do_req(1, 0, 32'h40, 0, 0, rd, lat);
    check("first_read_data", rd, {32{8'hA5}});
    check("first_read_fill_addr", obs_fill_addr, 32'h40);
    check("first_read_latency", lat, 6);

    do_req(1, 0, 32'h40, 0, 0, rd, lat);
    check("repeat_read_latency", lat, 1);
    check("repeat_read_no_fill", saw_read, 1'b0);

    do_req(0, 1, 32'h40, 32'h1, {{31{8'hFF}}, 8'h3C}, rd, lat);
    check("write_hit_latency", lat, 1);
    do_req(1, 0, 32'h40, 0, 0, rd, lat);
    check("read_after_write", rd, {{31{8'hA5}}, 8'h3C});

    do_req(1, 0, 32'h140, 0, 0, rd, lat);
    check("dirty_wb_addr", obs_wb_addr, 32'h40);
    check("dirty_wb_byte0", obs_wb_data[7:0], 8'h3C);
    check("dirty_fill_addr", obs_fill_addr, 32'h140);
    check("dirty_read_data", rd, {32{8'h1B}});
    check("dirty_miss_latency", lat, 9);

    mem_lat = 1;
    do_req(0, 1, 32'h60, 32'hF0F0_0000, {32{8'h11}}, rd, lat);
    check("write_miss_latency", lat, 4);
    mem_lat = 3;
    do_req(1, 0, 32'h60, 0, 0, rd, lat);

    do_req(1, 1, 32'h140, 32'h8000_0000, {8'hEE, 248'h0}, rd, lat);
    do_req(1, 0, 32'h140, 0, 0, rd, lat);
    check("both_req_is_write", rd, {8'hEE, {31{8'h1B}}});

    do_req(0, 1, 32'h40, 32'h2, {32{8'h77}}, rd, lat);
    check("dirty_write_wb_addr", obs_wb_addr, 32'h140);
    do_req(1, 0, 32'h40, 0, 0, rd, lat);
    check("refill_merge_data", rd, {{30{8'hA5}}, 8'h77, 8'h3C});

    mem_lat = 20;
    @(posedge clk); #1;
    predict(0, 32'h80, 0, 0);
    saw_read = 1'b0; saw_write = 1'b0;
    up_address = 32'h80; up_read = 1'b1; exp_active = 1'b1;
    for (int k = 0; k < 50 && !mem_read; k++) begin
      @(posedge clk); #1;
    end
    check("fill_started", mem_read, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; up_read = 1'b0; exp_active = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_drops_fill", mem_read, 1'b0);
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    mem_lat = 3;
    do_req(1, 0, 32'h80, 0, 0, rd, lat);
    check("post_reset_miss", saw_read, 1'b1);
    check("post_reset_fill_addr", obs_fill_addr, 32'h80);
    do_req(1, 0, 32'h40, 0, 0, rd, lat);
    check("reset_clears_valid", saw_read, 1'b1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
